// File: rtl/psum_ofifo_pkg.sv
// psum_ofifo_pkg: default sizes and pointer-width helper for the psum output FIFO
package psum_ofifo_pkg;
    localparam int COL_DEF = 8;
    localparam int PSUM_BW_DEF = 16;
    localparam int DEPTH_DEF = 64;
    // Pointers carry one extra wrap bit above the address bits
    function automatic int ptr_w(input int d);
        return $clog2(d) + 1;
    endfunction
endpackage

// File: rtl/psum_fifo_col.sv
// psum_fifo_col: one-column first-word-fall-through FIFO with wrap-bit pointers
module psum_fifo_col
    import psum_ofifo_pkg::*;
#(
    parameter int bw = PSUM_BW_DEF,
    parameter int depth = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [bw-1:0] din_i,
    input  logic          push_i,
    input  logic          pop_i,
    output logic [bw-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int PW = ptr_w(depth);
    localparam int AW = PW - 1;
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [bw-1:0] mem_q [depth];
    logic push_ok, pop_ok;
    assign empty_o = wp_q == rp_q;
    assign full_o = (wp_q[PW-1] != rp_q[PW-1]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign push_ok = push_i & ~full_o;
    assign pop_ok = pop_i & ~empty_o;
    assign dout_o = mem_q[rp_q[AW-1:0]];
    // Advance each pointer only on an accepted push or pop
    always_comb begin
        wp_d = wp_q + PW'(push_ok);
        rp_d = rp_q + PW'(pop_ok);
    end
    // Pointer registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end
    end
    // Storage is not reset; only accepted pushes write it
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wp_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/psum_ofifo.sv
// psum_ofifo: per-column psum output FIFO bank with row-wide pop; optional ReLU on out via PSUM_OFIFO_RELU_EN
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int col = COL_DEF,
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int depth = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow
);
    logic [col-1:0] full_w, empty_w;
    logic [psum_bw*col-1:0] head_w;
    logic pop_w, ovf_q, ovf_d;
    assign o_valid = &(~empty_w);
    assign o_full = |full_w;
    assign o_ready = ~o_full;
    assign o_overflow = ovf_q;
    assign pop_w = rd & o_valid;
    genvar c;
    generate
        for (c = 0; c < col; c++) begin : g_col
            psum_fifo_col #(.bw(psum_bw), .depth(depth)) u_col (
                .clk    (clk),
                .reset  (reset),
                .din_i  (in[psum_bw*c +: psum_bw]),
                .push_i (wr[c]),
                .pop_i  (pop_w),
                .dout_o (head_w[psum_bw*c +: psum_bw]),
                .full_o (full_w[c]),
                .empty_o(empty_w[c])
            );
`ifdef PSUM_OFIFO_RELU_EN
            assign out[psum_bw*c +: psum_bw] = head_w[psum_bw*(c+1)-1] ? '0 : head_w[psum_bw*c +: psum_bw];
`else
            assign out[psum_bw*c +: psum_bw] = head_w[psum_bw*c +: psum_bw];
`endif
        end
    endgenerate
    // Overflow latches once any push hits a full column
    always_comb ovf_d = ovf_q | (|(wr & full_w));
    // Sticky overflow register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ovf_q <= 1'b0;
        else ovf_q <= ovf_d;
    end
endmodule

// File: tb/tb_psum_ofifo.sv
// tb_psum_ofifo: randomized and directed checks of psum_ofifo against a per-column queue model
module tb_psum_ofifo;
    localparam int COL = 8;
    localparam int BW = 16;
    localparam int DEP = 64;
    logic clk = 0;
    logic reset = 0;
    logic [BW*COL-1:0] in_d = '0;
    logic [COL-1:0] wr = '0;
    logic rd = 0;
    logic [BW*COL-1:0] out;
    logic o_valid, o_full, o_ready, o_overflow;
    int n_chk = 0;
    int n_pass = 0;
    logic [BW-1:0] mq [COL][$];
    bit movf = 0;

    psum_ofifo #(.col(COL), .psum_bw(BW), .depth(DEP)) dut (
        .clk(clk), .reset(reset), .in(in_d), .wr(wr), .rd(rd), .out(out),
        .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    function automatic bit m_valid();
        for (int c = 0; c < COL; c++) if (mq[c].size() == 0) return 0;
        return 1;
    endfunction

    function automatic bit m_full();
        for (int c = 0; c < COL; c++) if (mq[c].size() == DEP) return 1;
        return 0;
    endfunction

    function automatic logic [BW*COL-1:0] m_out();
        logic [BW*COL-1:0] r;
        logic [BW-1:0] h;
        r = '0;
        for (int c = 0; c < COL; c++) begin
            h = mq[c][0];
`ifdef PSUM_OFIFO_RELU_EN
            if ($signed(h) < 0) h = '0;
`endif
            r[c*BW +: BW] = h;
        end
        return r;
    endfunction

    task automatic check_all();
        chk("valid", 128'(o_valid), 128'(m_valid()));
        chk("full", 128'(o_full), 128'(m_full()));
        chk("ready", 128'(o_ready), 128'(!m_full()));
        chk("ovf", 128'(o_overflow), 128'(movf));
        if (m_valid()) chk("out", 128'(out), 128'(m_out()));
    endtask

    task automatic step(input logic [COL-1:0] w, input logic r, input logic [BW*COL-1:0] d);
        bit v;
        int sz [COL];
        v = m_valid();
        for (int c = 0; c < COL; c++) sz[c] = mq[c].size();
        wr = w;
        rd = r;
        in_d = d;
        @(posedge clk);
        #1;
        for (int c = 0; c < COL; c++) begin
            if (r && v) void'(mq[c].pop_front());
            if (w[c]) begin
                if (sz[c] < DEP) mq[c].push_back(d[c*BW +: BW]);
                else movf = 1;
            end
        end
        wr = '0;
        rd = 0;
        check_all();
    endtask

    task automatic do_reset();
        wr = '1;
        rd = 1;
        in_d = {COL{16'hDEAD}};
        reset = 1;
        #2;
        for (int c = 0; c < COL; c++) mq[c].delete();
        movf = 0;
        check_all();
        @(posedge clk);
        #1;
        reset = 0;
        wr = '0;
        rd = 0;
        check_all();
    endtask

    function automatic logic [BW*COL-1:0] rnd_row();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [BW*COL-1:0] inc_row(input int k);
        logic [BW*COL-1:0] r;
        for (int c = 0; c < COL; c++) r[c*BW +: BW] = BW'(k * COL + c);
        return r;
    endfunction

    initial begin
        logic [BW*COL-1:0] row;
        do_reset();
        for (int c = 0; c < COL; c++) begin
            row = '0;
            row[c*BW +: BW] = BW'(16'h0100 + c);
            step(COL'(1) << c, 0, row);
        end
        chk("skew_valid", 128'(o_valid), 128'(1));
        chk("skew_out", 128'(out), 128'h0107_0106_0105_0104_0103_0102_0101_0100);
        step('0, 1, '0);
        for (int k = 0; k < DEP; k++) step('1, 0, rnd_row());
        chk("fill_full", 128'(o_full), 128'(1));
        chk("fill_ready", 128'(o_ready), 128'(0));
        row = m_out();
        step('1, 0, rnd_row());
        chk("ovf_set", 128'(o_overflow), 128'(1));
        chk("head_keep", 128'(out), 128'(row));
        step('1, 1, rnd_row());
        for (int k = 0; k < 5; k++) step('0, 1, '0);
        do_reset();
        for (int k = 0; k < 4; k++) step('1, 0, inc_row(k));
        for (int k = 4; k < 404; k++) step('1, 1, inc_row(k));
        do_reset();
        step(8'hF7, 1, rnd_row());
        step('0, 1, '0);
        step(8'h77, 1, rnd_row());
        step(8'h08, 1, rnd_row());
        chk("early_valid", 128'(o_valid), 128'(1));
        step('0, 1, '0);
        row = '0;
        row[0 +: BW] = 16'hFFF6;
        row[BW +: BW] = 16'h000A;
        step('1, 0, row);
        step('0, 1, '0);
        step('0, 1, '0);
        chk("relu_c0", 128'(out[0 +: BW]), 128'(m_out() & 128'hFFFF));
        for (int k = 0; k < 10; k++) step('1, 0, rnd_row());
        step('1, 0, rnd_row());
        do_reset();
        chk("rst_valid", 128'(o_valid), 128'(0));
        step('1, 0, 128'h1111_2222_3333_4444_5555_6666_7777_0888);
        chk("post_rst_row", 128'(out), 128'(m_out()));
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) do_reset();
            step(COL'($urandom & $urandom | $urandom & 32'h0000_0055), $urandom_range(0, 3) != 0 && k % 400 > 60, rnd_row());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
